fetch_issue_ctrl: RTL and testbench

- Fetch-side responder to the pipeline stall request (`noop`).
- Owns the PC, drives the synchronous instruction-memory address, and loads the fetch→decode pipeline latch.
- Inserts a NOP bubble whenever stall is requested; redirects on execute-stage branch/JAL resolution.
- Exposes the decode-stage opcode that feeds the stall logic, closing the hazard loop.

---
 rtl/pipe_defs.sv | 20 ++
 rtl/fetch_pc_sel.sv | 39 +++
 rtl/fetch_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_issue_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_defs.sv
// Shared pipeline definitions: opcode constants, fetch FSM state encoding
// and the default bubble instruction.
package pipe_defs;

  localparam logic [3:0] OP_LW    = 4'b0111;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BCOND = 4'b0010;
  localparam logic [3:0] OP_JAL   = 4'b0110;
  localparam logic [3:0] OP_NOP   = 4'b0000;

  // Bubble encoding; its opcode field is OP_NOP so the stall logic releases.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-fetch-address priority mux. Purely combinational:
// reset > BOOT > HALTED hold > redirect > halt > noop > sequential +4.
module fetch_pc_sel
  import pipe_defs::*;
#(
  parameter int unsigned           PCBITS   = 32,
  parameter logic [PCBITS-1:0]     RESET_PC = '0
) (
  input  logic              reset,
  input  fetch_state_e      state_q,
  input  logic              redirect_valid,
  input  logic [PCBITS-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              noop,
  input  logic [PCBITS-1:0] pc_q,
  output logic [PCBITS-1:0] pc_next
);

  // Select the address presented to IMEM this cycle.
  always_comb begin
    pc_next = pc_q;
    if (reset) begin
      pc_next = RESET_PC;
    end else begin
      unique case (state_q)
        ST_BOOT:   pc_next = RESET_PC;
        ST_HALTED: pc_next = pc_q;
        ST_RUN: begin
          if (redirect_valid)  pc_next = redirect_pc;
          else if (halt_req)   pc_next = pc_q;
          else if (noop)       pc_next = pc_q;
          else                 pc_next = pc_q + PCBITS'(4); // wraps modulo 2^PCBITS
        end
        default:   pc_next = RESET_PC;
      endcase
    end
  end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch stage controller: owns the PC, addresses a 1-cycle-latency IMEM and
// loads the fetch->decode latch, inserting bubbles on stall/redirect/halt.
// Optional build macro FETCH_STATS_EN adds bubble/redirect counters.
//
// Decode latch contract: valid_D=1 means inst_D/pc_D hold a real fetched
// instruction; valid_D=0 means a bubble (inst_D=NOP_INST, pc_D unchanged).
// There is no back-pressure: the consumer takes inst_D every cycle.
module fetch_issue_ctrl
  import pipe_defs::*;
#(
  parameter int unsigned             PCBITS   = 32,
  parameter int unsigned             INSTBITS = 32,
  parameter int unsigned             OPBITS   = 4,
  parameter logic [PCBITS-1:0]       RESET_PC = '0,
  parameter logic [INSTBITS-1:0]     NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                noop,
  input  logic                redirect_valid,
  input  logic [PCBITS-1:0]   redirect_pc,
  input  logic                halt_req,
  output logic [PCBITS-1:0]   imem_addr,
  input  logic [INSTBITS-1:0] imem_rdata,
  output logic [INSTBITS-1:0] inst_D,
  output logic [PCBITS-1:0]   pc_D,
  output logic                valid_D,
  output logic [OPBITS-1:0]   op_D,
  output logic                halted,
  output logic [1:0]          state_dbg
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_bubbles,
  output logic [31:0]         stat_redirects
`endif
);

  fetch_state_e        state_q, state_d;
  logic [PCBITS-1:0]   pc_q, pc_next;
  logic [INSTBITS-1:0] inst_q;
  logic [PCBITS-1:0]   pc_d_q;
  logic                valid_q;
  logic                load_real;

  fetch_pc_sel #(
    .PCBITS   (PCBITS),
    .RESET_PC (RESET_PC)
  ) u_pc_sel (
    .reset          (reset),
    .state_q        (state_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .noop           (noop),
    .pc_q           (pc_q),
    .pc_next        (pc_next)
  );

  // FSM next state and whether the decode latch takes the fetched word.
  always_comb begin
    state_d   = state_q;
    load_real = 1'b0;
    unique case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid)  state_d = ST_RUN;      // wrong-path word, halt dropped
        else if (halt_req)   state_d = ST_HALTED;
        else if (noop)       state_d = ST_RUN;
        else                 load_real = 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  // State, PC and decode latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc_d_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_next;
      if (load_real) begin
        inst_q  <= imem_rdata;
        pc_d_q  <= pc_q;
        valid_q <= 1'b1;
      end else begin
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr = pc_next;
  assign inst_D    = inst_q;
  assign pc_D      = pc_d_q;
  assign valid_D   = valid_q;
  assign op_D      = inst_q[INSTBITS-1 -: OPBITS];
  assign halted    = (state_q == ST_HALTED);
  assign state_dbg = state_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_bubbles_q, stat_redirects_q;

  // Saturating counters of noop bubbles and redirects seen in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bubbles_q   <= '0;
      stat_redirects_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (redirect_valid && (stat_redirects_q != '1))
        stat_redirects_q <= stat_redirects_q + 32'd1;
      if (!redirect_valid && !halt_req && noop && (stat_bubbles_q != '1))
        stat_bubbles_q <= stat_bubbles_q + 32'd1;
    end
  end

  assign stat_bubbles   = stat_bubbles_q;
  assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl with a 1-cycle-latency IMEM model.
module tb_fetch_issue_ctrl;
  import pipe_defs::*;

  logic        clk;
  logic        reset;
  logic        noop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_D;
  logic [31:0] pc_D;
  logic        valid_D;
  logic [3:0]  op_D;
  logic        halted;
  logic [1:0]  state_dbg;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_bubbles;
  logic [31:0] stat_redirects;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] W_A = 32'h7000_0000; // IMEM[0x00]
  localparam logic [31:0] W_B = 32'h3000_0004; // IMEM[0x04]
  localparam logic [31:0] W_C = 32'h2000_0008; // IMEM[0x08]
  localparam logic [31:0] W_D = 32'h6000_000C; // IMEM[0x0C]
  localparam logic [31:0] W_E = 32'h7000_0040; // IMEM[0x40]

  fetch_issue_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .noop           (noop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_D         (inst_D),
    .pc_D           (pc_D),
    .valid_D        (valid_D),
    .op_D           (op_D),
    .halted         (halted),
    .state_dbg      (state_dbg)
`ifdef FETCH_STATS_EN
    ,
    .stat_bubbles   (stat_bubbles),
    .stat_redirects (stat_redirects)
`endif
  );

  // Clock and IMEM model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem_word = W_A;
      32'h0000_0004: imem_word = W_B;
      32'h0000_0008: imem_word = W_C;
      32'h0000_000C: imem_word = W_D;
      32'h0000_0040: imem_word = W_E;
      default:       imem_word = {4'h1, a[27:0]};
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= imem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] exp_pc_d);
    check_eq({tag, "_valid"}, 32'(valid_D), 32'd0);
    check_eq({tag, "_inst"},  inst_D, 32'h0);
    check_eq({tag, "_op"},    32'(op_D), 32'd0);
    check_eq({tag, "_pcD"},   pc_D, exp_pc_d);
  endtask

  task automatic check_real(input string tag, input logic [31:0] exp_inst, input logic [31:0] exp_pc_d);
    check_eq({tag, "_valid"}, 32'(valid_D), 32'd1);
    check_eq({tag, "_inst"},  inst_D, exp_inst);
    check_eq({tag, "_op"},    32'(op_D), 32'(exp_inst[31:28]));
    check_eq({tag, "_pcD"},   pc_D, exp_pc_d);
  endtask

  initial begin
    reset = 1'b1; noop = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt_req = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_addr",   imem_addr, 32'h0);
    check_eq("rst_state",  32'(state_dbg), 32'(ST_BOOT));
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_bubble("rst", 32'h0);

    // Free run from reset: BOOT, then A,B,C
    reset = 1'b0; #1;
    check_eq("boot_addr", imem_addr, 32'h0);
    tick();
    check_eq("c1_valid", 32'(valid_D), 32'd0);
    check_eq("c1_state", 32'(state_dbg), 32'(ST_RUN));
    check_eq("c1_addr",  imem_addr, 32'h4);
    tick();
    check_real("c2", W_A, 32'h0);
    check_eq("c2_addr", imem_addr, 32'h8);
    tick();
    check_real("c3", W_B, 32'h4);
    check_eq("c3_addr", imem_addr, 32'hC);

    // noop for 3 cycles while pc_q = 8
    noop = 1'b1; #1;
    check_eq("noop_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bubble($sformatf("noop%0d", i), 32'h4);
      check_eq($sformatf("noop%0d_addr", i), imem_addr, 32'h8);
    end
    noop = 1'b0; #1;
    check_eq("rel_addr", imem_addr, 32'hC);
    tick();
    check_real("rel", W_C, 32'h8);
    check_eq("rel_addr2", imem_addr, 32'h10);

    // Redirect to 0x40 with simultaneous noop, pc_q = 12
    redirect_valid = 1'b1; redirect_pc = 32'h40; noop = 1'b1; #1;
    check_eq("redir_addr", imem_addr, 32'h40);
    tick();
    redirect_valid = 1'b0; noop = 1'b0;
    check_bubble("redir_bub", 32'h8);
    #1;
    check_eq("redir_addr2", imem_addr, 32'h44);
    tick();
    check_real("redir_E", W_E, 32'h40);

    // halt + redirect together: redirect wins, halt dropped
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
    check_eq("hr_addr", imem_addr, 32'h80);
    tick();
    halt_req = 1'b0; redirect_valid = 1'b0;
    check_eq("hr_halted", 32'(halted), 32'd0);
    check_eq("hr_state",  32'(state_dbg), 32'(ST_RUN));
    check_bubble("hr_bub", 32'h40);
    tick();
    check_real("hr_next", 32'h1000_0080, 32'h80);

    // PC wrap at all-ones
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0; #1;
    check_eq("wrap_addr1", imem_addr, 32'h0);
    tick();
    check_real("wrap", 32'h1FFF_FFFC, 32'hFFFF_FFFC);
    check_eq("wrap_addr2", imem_addr, 32'h4);

    // halt alone, then HALTED ignores everything but reset
    halt_req = 1'b1; #1;
    check_eq("halt_addr", imem_addr, 32'h0);
    tick();
    halt_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100; noop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("halt%0d_halted", i), 32'(halted), 32'd1);
      check_eq($sformatf("halt%0d_state", i), 32'(state_dbg), 32'(ST_HALTED));
      check_bubble($sformatf("halt%0d", i), 32'hFFFF_FFFC);
      check_eq($sformatf("halt%0d_addr", i), imem_addr, 32'h0);
      tick();
    end
    redirect_valid = 1'b0; noop = 1'b0;
    reset = 1'b1; #1;
    check_eq("hrst_addr", imem_addr, 32'h0);
    tick();
    check_eq("hrst_state",  32'(state_dbg), 32'(ST_BOOT));
    check_eq("hrst_halted", 32'(halted), 32'd0);

    // Fresh run: 2 noop bubbles + 1 redirect, then reset mid-noop
    reset = 1'b0;
    tick();             // BOOT -> RUN
    tick();             // A loaded, pc_q = 4
    check_real("s_A", W_A, 32'h0);
    noop = 1'b1;
    tick(); tick();
    noop = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_STATS_EN
    check_eq("stat_bub", stat_bubbles, 32'd2);
    check_eq("stat_red", stat_redirects, 32'd1);
`endif
    tick();
    check_real("s_E", W_E, 32'h40);
    noop = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_eq("mrst_state", 32'(state_dbg), 32'(ST_BOOT));
    check_bubble("mrst", 32'h0);
    check_eq("mrst_addr", imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
    check_eq("mrst_sbub", stat_bubbles, 32'd0);
    check_eq("mrst_sred", stat_redirects, 32'd0);
`endif
    reset = 1'b0; #1;
    check_eq("mrst_boot_addr", imem_addr, 32'h0);
    tick();
    check_eq("mrst_c1_valid", 32'(valid_D), 32'd0);
    noop = 1'b0;
    tick();
    check_real("mrst_c2", W_A, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
